// File: rtl/window_pointer_unit_if.sv
// Request/status bundle between the control unit and window_pointer_unit.
//
// The control unit (master) drives the window-move requests and the WRPSR/WRWIM
// writes. The window pointer unit (slave) returns the current CWP and WIM, the
// registered trap/illegal pulses and the trap-pending flag.
//
// Signals:
//   save, restore, rett       window move requests, one cycle each
//   trap_enter                trap entry, decrements cwp unconditionally
//   psr_wr, cwp_in            WRPSR strobe and new CWP value
//   wim_wr, wim_in            WRWIM strobe and new WIM value
//   cwp, wim                  current window pointer / invalid mask
//   ovf_trap, unf_trap        one-cycle window overflow / underflow pulses
//   illegal                   one-cycle pulse on conflicting requests
//   trap_pend                 high while waiting for trap entry
interface window_pointer_unit_if #(
    parameter int NWIN  = 4,
    parameter int CWP_W = 2
);
    logic             save;
    logic             restore;
    logic             rett;
    logic             trap_enter;
    logic             psr_wr;
    logic [CWP_W-1:0] cwp_in;
    logic             wim_wr;
    logic [NWIN-1:0]  wim_in;
    logic [CWP_W-1:0] cwp;
    logic [NWIN-1:0]  wim;
    logic             ovf_trap;
    logic             unf_trap;
    logic             illegal;
    logic             trap_pend;

    // Control side: issues requests, observes window state.
    modport master (
        output save, restore, rett, trap_enter, psr_wr, cwp_in, wim_wr, wim_in,
        input  cwp, wim, ovf_trap, unf_trap, illegal, trap_pend
    );

    // Window pointer unit side.
    modport slave (
        input  save, restore, rett, trap_enter, psr_wr, cwp_in, wim_wr, wim_in,
        output cwp, wim, ovf_trap, unf_trap, illegal, trap_pend
    );
endinterface

// File: rtl/window_pointer_unit.sv
// SPARC V8 Current Window Pointer / Window Invalid Mask holder.
//
// Executes SAVE/RESTORE/RETT/trap-entry window moves and WRPSR/WRWIM writes,
// detects window overflow/underflow against the WIM, and holds a trap-pending
// state until control acknowledges with trap entry. The cwp output feeds
// register_file_coupler directly.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    window_pointer_unit_if.slave: requests in, cwp/wim/pulses out
module window_pointer_unit #(
    parameter int NWIN  = 4,
    parameter int CWP_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    window_pointer_unit_if.slave  bus
);

    typedef enum logic {
        RUN,
        TRAPPED
    } state_t;

    state_t           state_q, state_nxt;
    logic [CWP_W-1:0] cwp_q, cwp_nxt;
    logic [NWIN-1:0]  wim_q, wim_nxt;
    logic             ovf_q, ovf_nxt;
    logic             unf_q, unf_nxt;
    logic             ill_q, ill_nxt;

    logic [CWP_W-1:0] cwp_dec;
    logic [CWP_W-1:0] cwp_inc;
    logic             conflict;

    // Window neighbours. NWIN is a power of two, so the natural wrap of a
    // CWP_W-bit add/subtract gives the modulo-NWIN arithmetic for free.
    always_comb begin
        cwp_dec  = cwp_q - CWP_W'(1);
        cwp_inc  = cwp_q + CWP_W'(1);
        conflict = (bus.save & bus.restore) | (bus.save & bus.rett) |
                   (bus.restore & bus.rett);
    end

    // Next-state logic. At most one cwp action is chosen per cycle by the
    // priority chain. The WIM write runs alongside whatever cwp action is
    // chosen, while the overflow/underflow checks look at the old wim_q.
    // Pulses default to zero so they only ever last a single cycle.
    always_comb begin
        state_nxt = state_q;
        cwp_nxt   = cwp_q;
        wim_nxt   = bus.wim_wr ? bus.wim_in : wim_q;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        ill_nxt   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.trap_enter) begin
                    cwp_nxt = cwp_dec;
                end else if (bus.psr_wr) begin
                    cwp_nxt = bus.cwp_in;
                end else if (conflict) begin
                    ill_nxt = 1'b1;
                end else if (bus.save) begin
                    if (wim_q[cwp_dec]) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = TRAPPED;
                    end else begin
                        cwp_nxt = cwp_dec;
                    end
                end else if (bus.restore || bus.rett) begin
                    if (wim_q[cwp_inc]) begin
                        unf_nxt   = 1'b1;
                        state_nxt = TRAPPED;
                    end else begin
                        cwp_nxt = cwp_inc;
                    end
                end
            end

            TRAPPED: begin
                // Window moves are dropped here; only trap entry leaves.
                if (bus.trap_enter) begin
                    cwp_nxt   = cwp_dec;
                    state_nxt = RUN;
                end else if (bus.psr_wr) begin
                    cwp_nxt = bus.cwp_in;
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State register. Reset drops any pending trap and clears all pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cwp_q   <= '0;
            wim_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cwp_q   <= cwp_nxt;
            wim_q   <= wim_nxt;
            ovf_q   <= ovf_nxt;
            unf_q   <= unf_nxt;
            ill_q   <= ill_nxt;
        end
    end

    // Outputs come straight from registers.
    assign bus.cwp       = cwp_q;
    assign bus.wim       = wim_q;
    assign bus.ovf_trap  = ovf_q;
    assign bus.unf_trap  = unf_q;
    assign bus.illegal   = ill_q;
    assign bus.trap_pend = (state_q == TRAPPED);

endmodule

// File: tb/tb_window_pointer_unit.sv
// Directed testbench for window_pointer_unit.
//
// Drives hand-built request vectors through the interface and compares cwp,
// wim, the trap/illegal pulses and trap_pend against hand-computed values.
module tb_window_pointer_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    window_pointer_unit_if #(.NWIN(4), .CWP_W(2)) bus ();

    window_pointer_unit #(.NWIN(4), .CWP_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log a mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Hold one request vector across a single rising edge, then return to idle.
    // Returns #1 after the edge so registered outputs are settled for checking.
    task automatic applyStimulus(input logic sv, input logic rs, input logic rt,
                                 input logic te, input logic pw,
                                 input logic [1:0] ci, input logic ww,
                                 input logic [3:0] wi);
        bus.save       = sv;
        bus.restore    = rs;
        bus.rett       = rt;
        bus.trap_enter = te;
        bus.psr_wr     = pw;
        bus.cwp_in     = ci;
        bus.wim_wr     = ww;
        bus.wim_in     = wi;
        @(posedge clk);
        #1;
        bus.save       = 1'b0;
        bus.restore    = 1'b0;
        bus.rett       = 1'b0;
        bus.trap_enter = 1'b0;
        bus.psr_wr     = 1'b0;
        bus.cwp_in     = 2'd0;
        bus.wim_wr     = 1'b0;
        bus.wim_in     = 4'd0;
    endtask

    // Load cwp and wim together through WRPSR + WRWIM.
    task automatic setWindow(input logic [1:0] c, input logic [3:0] w);
        applyStimulus(0, 0, 0, 0, 1, c, 1, w);
    endtask

    task automatic checkPulses(input string tag, input logic o, input logic u,
                               input logic i, input logic p);
        checkOutput({tag, "_ovf"},  8'(bus.ovf_trap),  8'(o));
        checkOutput({tag, "_unf"},  8'(bus.unf_trap),  8'(u));
        checkOutput({tag, "_ill"},  8'(bus.illegal),   8'(i));
        checkOutput({tag, "_pend"}, 8'(bus.trap_pend), 8'(p));
    endtask

    // Main directed sequence.
    initial begin
        logic [1:0] exp_cwp [4];
        checks = 0;
        errors = 0;

        // Reset held with random request activity on the inputs.
        rst_n          = 1'b0;
        bus.save       = 1'($urandom);
        bus.restore    = 1'($urandom);
        bus.rett       = 1'($urandom);
        bus.trap_enter = 1'($urandom);
        bus.psr_wr     = 1'($urandom);
        bus.cwp_in     = 2'($urandom);
        bus.wim_wr     = 1'($urandom);
        bus.wim_in     = 4'($urandom);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cwp", 8'(bus.cwp), 8'd0);
        checkOutput("rst_wim", 8'(bus.wim), 8'd0);
        checkPulses("rst", 0, 0, 0, 0);

        bus.save = 0; bus.restore = 0; bus.rett = 0; bus.trap_enter = 0;
        bus.psr_wr = 0; bus.cwp_in = 0; bus.wim_wr = 0; bus.wim_in = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four saves with an empty WIM walk the pointer down and wrap.
        exp_cwp = '{2'd3, 2'd2, 2'd1, 2'd0};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 2'd0, 0, 4'd0);
            checkOutput($sformatf("wrap_cwp%0d", k), 8'(bus.cwp), 8'(exp_cwp[k]));
            checkOutput($sformatf("wrap_ovf%0d", k), 8'(bus.ovf_trap), 8'd0);
        end

        // Overflow: cwp=3, wim[2]=1, save traps and holds cwp.
        setWindow(2'd3, 4'b0100);
        checkOutput("ovf_setup_wim", 8'(bus.wim), 8'b0100);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("ovf_cwp", 8'(bus.cwp), 8'd3);
        checkPulses("ovf", 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("ovf_ignored_cwp", 8'(bus.cwp), 8'd3);
        checkPulses("ovf_ignored", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 2'd0, 0, 4'd0);
        checkOutput("ovf_te_cwp", 8'(bus.cwp), 8'd2);
        checkPulses("ovf_te", 0, 0, 0, 0);

        // Underflow: cwp=3, wim[0]=1, restore traps.
        setWindow(2'd3, 4'b0001);
        applyStimulus(0, 1, 0, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("unf_cwp", 8'(bus.cwp), 8'd3);
        checkPulses("unf", 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 2'd0, 0, 4'd0);
        checkOutput("unf_te_cwp", 8'(bus.cwp), 8'd2);
        // From cwp=2 the RETT target is window 3, which is valid.
        applyStimulus(0, 0, 1, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("rett_cwp", 8'(bus.cwp), 8'd3);
        checkPulses("rett", 0, 0, 0, 0);

        // Priority: trap_enter beats psr_wr.
        setWindow(2'd0, 4'b0000);
        applyStimulus(0, 0, 0, 1, 1, 2'd1, 0, 4'd0);
        checkOutput("prio_cwp", 8'(bus.cwp), 8'd3);
        // Conflict: save+restore leaves cwp alone and raises illegal once.
        applyStimulus(1, 1, 0, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("conf_cwp", 8'(bus.cwp), 8'd3);
        checkPulses("conf", 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("conf_clear_ill", 8'(bus.illegal), 8'd0);

        // Same-cycle WIM write: the save checks the old (empty) mask.
        setWindow(2'd1, 4'b0000);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 1, 4'b0001);
        checkOutput("samewim_cwp", 8'(bus.cwp), 8'd0);
        checkOutput("samewim_wim", 8'(bus.wim), 8'b0001);
        checkPulses("samewim", 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("samewim_next_cwp", 8'(bus.cwp), 8'd3);

        // Full mask: restore traps; WRPSR still honoured while trapped.
        setWindow(2'd3, 4'b1111);
        applyStimulus(0, 1, 0, 0, 0, 2'd0, 0, 4'd0);
        checkPulses("full_unf", 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 2'd1, 0, 4'd0);
        checkOutput("trap_psr_cwp", 8'(bus.cwp), 8'd1);
        checkPulses("trap_psr", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 2'd0, 0, 4'd0);
        checkOutput("full_te_cwp", 8'(bus.cwp), 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("full_ovf_cwp", 8'(bus.cwp), 8'd0);
        checkPulses("full_ovf", 1, 0, 0, 1);

        // Async reset between edges while trapped and pulsing.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_cwp", 8'(bus.cwp), 8'd0);
        checkOutput("areset_wim", 8'(bus.wim), 8'd0);
        checkPulses("areset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Back in RUN with an empty mask: save moves the pointer.
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        checkOutput("post_rst_cwp", 8'(bus.cwp), 8'd3);
        checkPulses("post_rst", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
